// File: rtl/pop_ack_rr_arbiter.sv
// Round-robin arbiter sharing one blocking pop/ack destination among NUM_REQ requesters.
// Ack and read data pass straight through to the granted requester; a watchdog flags a stuck destination.
module pop_ack_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_pop,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [DATA_W-1:0]          req_rdata,
  output logic                       mem_pop,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int              ID_W      = $clog2(NUM_REQ);
  localparam bit              WD_EN     = (TIMEOUT_CYCLES > 0);
  localparam int              WD_W      = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX    = WD_W'(TIMEOUT_CYCLES);
  localparam logic [ID_W:0]   NUM_REQ_X = (ID_W + 1)'(NUM_REQ);

  typedef enum logic [0:0] {S_IDLE, S_WAIT_ACK} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ID_W-1:0]     r_grant_id;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [WD_W-1:0]     r_wd_cnt;
  logic                r_timeout_err;

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic [ID_W-1:0]      w_offset;
  logic [ID_W:0]        w_winner_sum;
  logic [ID_W-1:0]      w_winner;
  logic [ID_W-1:0]      w_ptr_next;
  logic                 w_any_req;
  logic                 w_ack_fire;
  logic                 w_wd_count;
  logic [WD_W-1:0]      w_wd_inc;

  // Rotating the doubled request vector puts the rr_ptr requester at bit 0,
  // so the lowest set bit is the distance from rr_ptr to the winner.
  assign w_req_dbl = {req_pop, req_pop};
  assign w_req_rot = w_req_dbl[r_rr_ptr +: NUM_REQ];
  assign w_any_req = |req_pop;

  always_comb begin
    w_offset = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_offset = ID_W'(i);
    end
  end

  assign w_winner_sum = {1'b0, r_rr_ptr} + {1'b0, w_offset};
  assign w_winner     = (w_winner_sum >= NUM_REQ_X) ? ID_W'(w_winner_sum - NUM_REQ_X)
                                                    : w_winner_sum[ID_W-1:0];
  assign w_ptr_next   = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

  assign w_ack_fire = (r_state == S_WAIT_ACK) && mem_ack;
  assign w_wd_inc   = r_wd_cnt + WD_W'(1);
  assign w_wd_count = WD_EN && (r_state == S_WAIT_ACK) && !mem_ack && (r_wd_cnt != WD_MAX);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_any_req) w_state_next = S_WAIT_ACK;
      S_WAIT_ACK: if (mem_ack)   w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_grant_id    <= '0;
      r_rr_ptr      <= '0;
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && w_any_req) begin
        r_grant_id <= w_winner;
        r_wd_cnt   <= '0;
      end
      if (w_ack_fire) r_rr_ptr <= w_ptr_next;
      // The transaction is never aborted; the flag only reports the stall.
      if (w_wd_count) begin
        r_wd_cnt <= w_wd_inc;
        if (w_wd_inc == WD_MAX) r_timeout_err <= 1'b1;
      end
    end
  end

  assign mem_pop     = (r_state == S_WAIT_ACK);
  assign busy        = (r_state == S_WAIT_ACK);
  assign grant_id    = r_grant_id;
  assign timeout_err = r_timeout_err;
  assign req_rdata   = mem_rdata;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign req_ack[gi] = w_ack_fire && (r_grant_id == ID_W'(gi));
    end
  endgenerate

endmodule
